// File: rtl/gowin_sp_ram.sv
// rtl/gowin_sp_ram.sv - Parametrised single-port BSRAM wrapper with byte enables and credit-buffered responses.
// Optional zero-fill after reset: define BGPU_SP_RAM_ZERO_INIT_EN.
module gowin_sp_ram #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Depth     = 1024,
  parameter int unsigned OutputReg = 0,
  parameter int unsigned WriteMode = 0,
  localparam int unsigned AddrWidth = $clog2(Depth),
  localparam int unsigned NumBytes  = DataWidth / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_we_i,
  input  logic [NumBytes-1:0]  req_be_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 busy_o
);

  localparam int unsigned Lat       = 1 + OutputReg;
  localparam int unsigned FifoDepth = Lat + 1;
  localparam int unsigned CntWidth  = $clog2(FifoDepth + 1);
  localparam int unsigned PtrWidth  = $clog2(FifoDepth);
  localparam logic [AddrWidth:0] DepthW = (AddrWidth + 1)'(Depth);

  typedef enum logic {CLEAR, RUN} state_e;

  logic [DataWidth-1:0] mem [Depth];

  state_e               state;
  logic                 accept;
  logic                 pop;
  logic                 in_range;
  logic [DataWidth-1:0] old_word;
  logic [DataWidth-1:0] merged;
  logic [DataWidth-1:0] rsp_word;
  logic [CntWidth-1:0]  cnt;

`ifdef BGPU_SP_RAM_ZERO_INIT_EN
  logic [AddrWidth-1:0] clr_addr;
`endif

  assign in_range = {1'b0, req_addr_i} < DepthW;
  assign accept   = req_valid_i && req_ready_o;
  assign old_word = in_range ? mem[req_addr_i] : '0;

  always_comb begin
    merged = old_word;
    for (int b = 0; b < NumBytes; b++) begin
      if (req_be_i[b]) merged[b*ByteWidth +: ByteWidth] = req_wdata_i[b*ByteWidth +: ByteWidth];
    end
  end

  // Out-of-range accesses never touch storage, so every mode answers them with zeros.
  always_comb begin
    rsp_word = old_word;
    if (req_we_i) begin
      case (WriteMode)
        1:       rsp_word = in_range ? merged : '0;
        2:       rsp_word = old_word;
        default: rsp_word = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
`ifdef BGPU_SP_RAM_ZERO_INIT_EN
      state    <= CLEAR;
      clr_addr <= '0;
`else
      state    <= RUN;
`endif
    end else begin
      case (state)
        CLEAR: begin
`ifdef BGPU_SP_RAM_ZERO_INIT_EN
          if (clr_addr == AddrWidth'(Depth - 1)) state <= RUN;
          else clr_addr <= clr_addr + 1'b1;
`else
          state <= RUN;
`endif
        end
        default: state <= RUN;
      endcase
    end
  end

  // Storage has no reset; the BSRAM tile keeps whatever it held.
  always_ff @(posedge clk_i) begin
`ifdef BGPU_SP_RAM_ZERO_INIT_EN
    if (state == CLEAR) mem[clr_addr] <= '0;
`endif
    if (accept && req_we_i && in_range) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (req_be_i[b]) mem[req_addr_i][b*ByteWidth +: ByteWidth] <= req_wdata_i[b*ByteWidth +: ByteWidth];
      end
    end
  end

  logic                 s1_valid;
  logic [DataWidth-1:0] s1_data;
  logic                 pipe_valid;
  logic [DataWidth-1:0] pipe_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) s1_valid <= 1'b0;
    else         s1_valid <= accept;
  end

  always_ff @(posedge clk_i) begin
    if (accept) s1_data <= rsp_word;
  end

  if (OutputReg != 0) begin : g_oreg
    logic                 s2_valid;
    logic [DataWidth-1:0] s2_data;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) s2_valid <= 1'b0;
      else         s2_valid <= s1_valid;
    end
    always_ff @(posedge clk_i) begin
      if (s1_valid) s2_data <= s1_data;
    end
    assign pipe_valid = s2_valid;
    assign pipe_data  = s2_data;
  end else begin : g_noreg
    assign pipe_valid = s1_valid;
    assign pipe_data  = s1_data;
  end

  logic [DataWidth-1:0] fifo_mem [FifoDepth];
  logic [PtrWidth-1:0]  wr_ptr;
  logic [PtrWidth-1:0]  rd_ptr;
  logic [CntWidth-1:0]  fifo_cnt;
  logic                 fifo_empty;

  assign fifo_empty  = (fifo_cnt == '0);
  assign rsp_valid_o = !fifo_empty;
  assign rsp_rdata_o = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign pop         = rsp_valid_o && rsp_ready_i;

  // The credit counter covers pipeline plus buffer, so a push never finds the FIFO full.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      cnt      <= '0;
    end else begin
      if (pipe_valid) wr_ptr <= (wr_ptr == PtrWidth'(FifoDepth - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)        rd_ptr <= (rd_ptr == PtrWidth'(FifoDepth - 1)) ? '0 : rd_ptr + 1'b1;
      case ({pipe_valid, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (pipe_valid) fifo_mem[wr_ptr] <= pipe_data;
  end

  assign req_ready_o = (state == RUN) && ((cnt < CntWidth'(FifoDepth)) || pop);
  assign busy_o      = (state != RUN) || (cnt != '0);

endmodule

// File: tb/tb_gowin_sp_ram.sv
// tb/tb_gowin_sp_ram.sv - Scoreboard bench for gowin_sp_ram (Depth 1000, OutputReg 1, WriteMode 2).
module tb_gowin_sp_ram;

`ifdef BGPU_SP_RAM_ZERO_INIT_EN
  localparam bit ZI = 1'b1;
`else
  localparam bit ZI = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        busy;

  always #5 clk = ~clk;

  gowin_sp_ram #(
    .DataWidth(32), .ByteWidth(8), .Depth(1000), .OutputReg(1), .WriteMode(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_be_i(req_be), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .busy_o(busy)
  );

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        chk;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        chk;
    logic [9:0]  addr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   accepted = 0;
  int   pops     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #2;
  endtask

  // Outputs are sampled 2 time units after the falling edge, the same point inputs become stable.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=%h required=none", rsp_rdata);
      end else begin
        mon_e = sb_q.pop_front();
        pops++;
        if (mon_e.chk) check($sformatf("rsp_addr%0d", mon_e.addr), rsp_rdata, mon_e.data);
      end
    end
  end

  task automatic do_req(input logic we, input logic [9:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] ex, input logic c,
                        output int waits);
    bit   done;
    logic rdy;
    done  = 1'b0;
    waits = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wd;
    while (!done) begin
      #2;
      rdy = req_ready;
      @(posedge clk);
      if (rdy) begin
        sb_q.push_back('{data: ex, chk: c, addr: addr});
        accepted++;
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 3000) begin
          checks++;
          failures++;
          $display("FAIL req_timeout actual=%0d required<=3000", waits);
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60 && sb_q.size() != 0; k++) sample();
    check({name, "_queue_empty"}, 32'(sb_q.size()), 32'd0);
    sample();
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] bp_data(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  vec_t vecs[19];
  int   w;
  int   pops0;
  int   n_valid;
  int   n_busy;
  int   n_stale;

  initial begin
    vecs[0]  = '{1'b1, 10'd7,    4'hF, 32'hDEADBEEF, 32'h00000000, ZI};
    vecs[1]  = '{1'b1, 10'd7,    4'h5, 32'h11223344, 32'hDEADBEEF, 1'b1};
    vecs[2]  = '{1'b0, 10'd7,    4'h0, 32'h0,        32'hDE22BE44, 1'b1};
    vecs[3]  = '{1'b1, 10'd3,    4'hF, 32'hAAAAAAAA, 32'h00000000, ZI};
    vecs[4]  = '{1'b1, 10'd3,    4'hF, 32'h55555555, 32'hAAAAAAAA, 1'b1};
    vecs[5]  = '{1'b0, 10'd3,    4'h0, 32'h0,        32'h55555555, 1'b1};
    vecs[6]  = '{1'b1, 10'd3,    4'h0, 32'hFFFFFFFF, 32'h55555555, 1'b1};
    vecs[7]  = '{1'b0, 10'd3,    4'h0, 32'h0,        32'h55555555, 1'b1};
    vecs[8]  = '{1'b1, 10'd1000, 4'hF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b0, 10'd1000, 4'h0, 32'h0,        32'h00000000, 1'b1};
    vecs[10] = '{1'b0, 10'd0,    4'h0, 32'h0,        32'h00000000, ZI};
    vecs[11] = '{1'b1, 10'd999,  4'hF, 32'hCAFEF00D, 32'h00000000, ZI};
    vecs[12] = '{1'b0, 10'd999,  4'h0, 32'h0,        32'hCAFEF00D, 1'b1};
    vecs[13] = '{1'b1, 10'd0,    4'h8, 32'hA5A5A5A5, 32'h00000000, ZI};
    vecs[14] = '{1'b1, 10'd0,    4'h7, 32'h01020304, 32'hA5000000, ZI};
    vecs[15] = '{1'b0, 10'd0,    4'h0, 32'h0,        32'hA5020304, 1'b1};
    vecs[16] = '{1'b1, 10'd1023, 4'hF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[17] = '{1'b0, 10'd999,  4'h0, 32'h0,        32'hCAFEF00D, 1'b1};
    vecs[18] = '{1'b0, 10'd1023, 4'h0, 32'h0,        32'h00000000, 1'b1};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_be = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, {31'd0, ~ZI});
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_busy", {31'd0, busy}, {31'd0, ZI});

    @(posedge clk);
    #1 rst_n = 1'b1;

    // First read is held off for the whole clear, then arrives two edges after acceptance.
    do_req(1'b0, 10'd5, 4'h0, 32'h0, 32'h0, ZI, w);
    check("clear_cycles", 32'(w), ZI ? 32'd1000 : 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #2 check("lat_edge0", {31'd0, rsp_valid}, 32'd0);
    sample();
    check("lat_edge1", {31'd0, rsp_valid}, 32'd0);
    sample();
    check("lat_edge2", {31'd0, rsp_valid}, 32'd1);
    drain("lat");

    for (int i = 0; i < 19; i++)
      do_req(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].exp, vecs[i].chk, w);
    idle();
    drain("table");

    for (int i = 0; i < 10; i++)
      do_req(1'b1, 10'(i), 4'hF, bp_data(i), 32'h0, 1'b0, w);
    idle();
    drain("bp_fill");

    @(negedge clk);
    rsp_ready = 1'b0;
    accepted  = 0;
    pops0     = pops;
    fork
      begin
        for (int i = 0; i < 10; i++) do_req(1'b0, 10'(i), 4'h0, 32'h0, bp_data(i), 1'b1, w);
        idle();
      end
    join_none
    repeat (8) sample();
    check("bp_accepted", 32'(accepted), 32'd3);
    check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_rsp_hold", rsp_rdata, bp_data(0));
    @(negedge clk);
    rsp_ready = 1'b1;
    n_valid   = 0;
    for (int k = 0; k < 10; k++) begin
      #2;
      if (rsp_valid) n_valid++;
      @(negedge clk);
    end
    check("bp_no_bubble", 32'(n_valid), 32'd10);
    wait fork;
    drain("bp");
    check("bp_rsp_count", 32'(pops - pops0), 32'd10);

    @(negedge clk);
    rsp_ready = 1'b0;
    do_req(1'b0, 10'd1, 4'h0, 32'h0, bp_data(1), 1'b1, w);
    do_req(1'b0, 10'd2, 4'h0, 32'h0, bp_data(2), 1'b1, w);
    idle();
    repeat (4) sample();
    check("pre_rst_buffered", {31'd0, rsp_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_async_rdata", rsp_rdata, 32'd0);
    check("rst_async_busy", {31'd0, busy}, {31'd0, ZI});
    sb_q.delete();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_busy  = 0;
    n_stale = 0;
    for (int k = 0; k < 1010; k++) begin
      sample();
      if (busy) n_busy++;
      if (rsp_valid) n_stale++;
    end
    check("rst_clear_busy", 32'(n_busy), ZI ? 32'd1000 : 32'd0);
    check("rst_no_stale", 32'(n_stale), 32'd0);

    do_req(1'b1, 10'd2, 4'hF, 32'h0BADCAFE, 32'h0, ZI, w);
    do_req(1'b0, 10'd2, 4'h0, 32'h0, 32'h0BADCAFE, 1'b1, w);
    idle();
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gowin_sp_ram.md
# gowin_sp_ram

Parametrised single-port RAM for Gowin targets. It is the successor to the raw fixed-32-bit SP BSRAM primitive. Width, depth, write mode and output pipelining are generic, and the block adds byte enables and a valid/ready request/response handshake with a credit-controlled response buffer. It sits between the shared-memory/register-file logic and the BSRAM tiles.

## Interface
- `DataWidth`, 32: word width in bits; multiple of `ByteWidth`.
- `ByteWidth`, 8: bits per byte-enable lane.
- `Depth`, 1024: number of words; ≥2, need not be a power of two.
- `OutputReg`, 0: 1 adds the output pipeline register. Read latency `LAT` = 1 + `OutputReg`.
- `WriteMode`, 0: response data on a write. 0 = all zeros (no read on write), 1 = write-through (new merged word), 2 = read-before-write (old word).
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: asynchronous active-low reset.
- `req_valid_i`, input, 1: request valid.
- `req_ready_o`, output, 1: request accepted when valid && ready.
- `req_addr_i`, input, `$clog2(Depth)`: word address.
- `req_we_i`, input, 1: 1 = write, 0 = read.
- `req_be_i`, input, `DataWidth/ByteWidth`: byte enables; ignored on reads.
- `req_wdata_i`, input, `DataWidth`: write data.
- `rsp_valid_o`, output, 1: response valid.
- `rsp_ready_i`, input, 1: response consumed when valid && ready.
- `rsp_rdata_o`, output, `DataWidth`: response data.
- `busy_o`, output, 1: clear in progress or any request in flight/buffered.

## Operation
- FSM states: `CLEAR` (only with the macro) and `RUN`. Reset enters `CLEAR` if compiled in, else `RUN`.
- Every accepted request produces exactly one response. Responses are in order.
- Writes update only lanes with `req_be_i` set. `be == 0` still produces a response and leaves memory unchanged.
- Write response data is selected by `WriteMode`. Read response data is the stored word.
- Address ≥ `Depth`:
  - Write is dropped.
  - Read returns zeros.
  - A response is still generated.
- Response buffer:
  - Fall-through FIFO, depth `LAT+1`.
  - Credit counter `cnt` = in-pipeline + buffered entries.
  - `req_ready_o` = `RUN` && (`cnt` < `LAT+1` || response popped this cycle).
  - `cnt` increments on accept and decrements on pop. Accept and pop in the same cycle leave it unchanged.
  - No response is ever dropped or overwritten.
- `busy_o` = (state == `CLEAR`) || `cnt` != 0.

## Timing
- Reset values:
  - `req_ready_o` = 0 with the macro, 1 without.
  - `rsp_valid_o` = 0.
  - `rsp_rdata_o` = 0.
  - `busy_o` = 1 with the macro, 0 without.
  - `cnt` = 0, FIFO empty.
- Accept at edge N gives `rsp_valid_o` = 1 after edge N+`LAT` when the FIFO is empty and `rsp_ready_i` is held 1.
- Throughput is one request per cycle while `rsp_ready_i` = 1.
- With `rsp_ready_i` = 0, at most `LAT+1` requests are accepted, then `req_ready_o` = 0.
- `rsp_valid_o`/`rsp_rdata_o` stay stable while valid && !ready.
- Read and write to the same address on consecutive cycles: the read returns the written data. No hazard, since the port serialises.
- Asynchronous reset mid-operation:
  - In-flight requests and buffered responses are discarded.
  - Memory contents are not guaranteed.
  - With the macro, the clear restarts from address 0.

## Configuration
- `BGPU_SP_RAM_ZERO_INIT_EN` defined:
  - After reset release, `CLEAR` writes zero to addresses 0..`Depth-1`, one per cycle.
  - `req_ready_o` = 0 for exactly `Depth` cycles, then the FSM enters `RUN`.
  - Requests arriving during `CLEAR` are held off by the handshake.
- Macro undefined:
  - No `CLEAR` state.
  - Initial contents are undefined (X in simulation).
  - `req_ready_o` is 1 from the first cycle after reset.

## Test plan
- Defaults, macro on:
  - Stimulus: release reset, assert `req_valid_i` read addr 5 from cycle 0.
  - Response: `req_ready_o` rises after exactly 1024 cycles; response `rdata` = 0x00000000 one cycle after accept.
- Write then read:
  - Stimulus: write addr 7, data 0xDEADBEEF, be 4'b1111; then write addr 7, data 0x11223344, be 4'b0101; then read addr 7.
  - Response: read returns 0xDE22BE44.
- `WriteMode` sweep:
  - Stimulus: addr 3 holds 0xAAAAAAAA; write 0x55555555, be 4'b1111.
  - Response: write response is 0 (mode 0), 0x55555555 (mode 1), 0xAAAAAAAA (mode 2).
- Backpressure, `OutputReg` = 1:
  - Stimulus: `rsp_ready_i` = 0, continuous reads to addrs 0..9.
  - Response: exactly 3 accepted, `req_ready_o` = 0, `rsp_valid_o` held with addr 0 data.
  - Stimulus: release `rsp_ready_i`.
  - Response: all 10 responses in order, with no bubbles after the first.
- Out-of-range, `Depth` = 1000:
  - Stimulus: write 0xFFFFFFFF at addr 1000, then read addr 1000 and addr 0.
  - Response: both reads return 0 (macro on); 2 responses plus the write response delivered.
- Reset mid-stream:
  - Stimulus: assert `rst_ni` low with 2 responses buffered.
  - Response: `rsp_valid_o` = 0 immediately (asynchronous); after release, no stale responses are emitted and `busy_o` follows the clear.
